// File: rtl/Verdata_pkg.sv
// Shared data-path types for the core.
package Verdata_pkg;
  typedef logic [31:0] word_t;
endpackage

// File: rtl/Veropcodes_pkg.sv
// Instruction encodings and fetch-side records.
package Veropcodes_pkg;
  import Verdata_pkg::*;

  // addi x0, x0, 0
  localparam word_t WORD_NOP = 32'h0000_0013;

  typedef struct packed {
    word_t pc;
    word_t instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_buffer.sv
// Synchronous FIFO of fetched {pc, instr} entries with single-cycle flush.
// Push and pop may coincide when full; pointers wrap modulo DEPTH.
module fetch_buffer
  import Veropcodes_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wr_data,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= bump(wr_ptr);
      if (pop)  rd_ptr <= bump(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wr_data;
  end

  assign head = mem[rd_ptr];

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && !flush && count == FULL));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && count == '0));

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch front end: issues word fetches, buffers responses in order,
// and handles redirects, including one arriving while a bus request is in flight.
module instr_fetch
  import Verdata_pkg::word_t;
  import Veropcodes_pkg::*;
#(
  parameter word_t RESET_PC = 32'h0000_0000,
  parameter int    DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        ibus_valid,
  output logic [31:0] ibus_address,
  input  logic        ibus_ready,
  input  logic [31:0] ibus_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // Handshake: a bus request transfers on ibus_valid && ibus_ready; once
  // ibus_valid is raised it and ibus_address stay put until ibus_ready.
  // The decode side transfers on out_valid && out_ready.
  typedef enum logic [1:0] {
    ST_RESET,  // first cycle out of reset, nothing issued
    ST_ISSUE,  // no request outstanding; fetch when buffer has room
    ST_WAIT,   // request held, response will be kept
    ST_DROP    // request held, redirected under it, response will be dropped
  } fetch_state_t;

  fetch_state_t state;
  fetch_state_t state_next;
  word_t        fpc;
  word_t        held_addr;
  word_t        target;
  logic [1:0]   unused_target_bits;
  logic [CW-1:0] count;
  fetch_entry_t head;
  fetch_entry_t wr_data;
  logic         pending;
  logic         discard;
  logic         accept;
  logic         stall;
  logic         push;
  logic         pop;

  assign target             = {redirect_pc[31:2], 2'b00};
  assign unused_target_bits = redirect_pc[1:0];

  assign pending      = (state == ST_WAIT) || (state == ST_DROP);
  assign discard      = (state == ST_DROP);
  assign ibus_valid   = pending || ((state == ST_ISSUE) && (count < FULL));
  assign ibus_address = pending ? held_addr : fpc;
  assign accept       = ibus_valid && ibus_ready;
  assign stall        = ibus_valid && !ibus_ready;
  assign push         = accept && !discard && !redirect_valid;

  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign out_pc    = out_valid ? head.pc : '0;
  assign out_instr = out_valid ? head.instr : WORD_NOP;
  assign wr_data   = '{pc: ibus_address, instr: ibus_rdata};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_RESET;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_RESET: state_next = ST_ISSUE;
      default: begin
        if (stall)
          state_next = (redirect_valid || discard) ? ST_DROP : ST_WAIT;
        else
          state_next = ST_ISSUE;
      end
    endcase
  end

  // A dropped response does not advance fpc: it already holds the redirect target.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fpc       <= RESET_PC;
      held_addr <= RESET_PC;
    end else begin
      if (redirect_valid) fpc <= target;
      else if (push)      fpc <= fpc + 32'd4;
      if (stall) held_addr <= ibus_address;
    end
  end

  fetch_buffer #(.DEPTH(DEPTH)) u_buffer (
    .clk     (clk),
    .rst_n   (reset_n),
    .push    (push),
    .pop     (pop),
    .flush   (redirect_valid),
    .wr_data (wr_data),
    .head    (head),
    .count   (count)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Directed vector table plus random stall/redirect/reset run against a queue model.
module tb_instr_fetch;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk;
  logic        reset_n;
  logic        ibus_valid;
  logic [31:0] ibus_address;
  logic        ibus_ready;
  logic [31:0] ibus_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  instr_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .ibus_valid     (ibus_valid),
    .ibus_address   (ibus_address),
    .ibus_ready     (ibus_ready),
    .ibus_rdata     (ibus_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " ibus_valid"}, {31'b0, ibus_valid}, 32'd0);
    check({tag, " out_valid"},  {31'b0, out_valid},  32'd0);
    check({tag, " out_instr"},  out_instr, NOP);
    check({tag, " out_pc"},     out_pc,    32'd0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        ordy;
    logic        e_iv;
    logic [31:0] e_addr;
    logic        e_ov;
    logic [31:0] e_pc;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic rdy, input logic rv, input logic [31:0] rpc,
                              input logic ordy, input logic e_iv, input logic [31:0] e_addr,
                              input logic e_ov, input logic [31:0] e_pc);
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.ordy = ordy;
    v.e_iv = e_iv; v.e_addr = e_addr; v.e_ov = e_ov; v.e_pc = e_pc;
    return v;
  endfunction

  task automatic apply_row(input vec_t v, input int idx);
    ibus_ready     = v.rdy;
    redirect_valid = v.rv;
    redirect_pc    = v.rpc;
    out_ready      = v.ordy;
    ibus_rdata     = mem_word(ibus_address);
    check($sformatf("row%0d ibus_valid", idx), {31'b0, ibus_valid}, {31'b0, v.e_iv});
    if (v.e_iv) check($sformatf("row%0d ibus_address", idx), ibus_address, v.e_addr);
    check($sformatf("row%0d out_valid", idx), {31'b0, out_valid}, {31'b0, v.e_ov});
    check($sformatf("row%0d out_pc", idx), out_pc, v.e_ov ? v.e_pc : 32'd0);
    check($sformatf("row%0d out_instr", idx), out_instr, v.e_ov ? mem_word(v.e_pc) : NOP);
    @(posedge clk); #1;
  endtask

  // ---------------- reference model state ----------------
  logic        m_run, m_pend, m_disc, m_iv, m_acc;
  logic [31:0] m_fpc, m_held, m_addr, m_tgt;
  logic        do_rst;

  initial begin
    reset_n = 1'b0; ibus_ready = 1'b0; ibus_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;

    // rdy rv rpc ordy | iv addr ov pc
    vecs[0]  = mk(1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         1'b0, 32'h0);
    vecs[1]  = mk(1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h4,         1'b1, 32'h0);
    vecs[2]  = mk(1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h8,         1'b1, 32'h0);
    vecs[3]  = mk(1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h8,         1'b1, 32'h0);
    vecs[4]  = mk(1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h8,         1'b1, 32'h0);
    vecs[5]  = mk(1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h8,         1'b1, 32'h0);
    vecs[6]  = mk(1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h8,         1'b1, 32'h4);
    vecs[7]  = mk(1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'hC,         1'b1, 32'h8);
    vecs[8]  = mk(1'b0, 1'b1, 32'h103,       1'b1, 1'b1, 32'h10,        1'b1, 32'hC);
    vecs[9]  = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h10,        1'b0, 32'h0);
    vecs[10] = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h10,        1'b0, 32'h0);
    vecs[11] = mk(1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h10,        1'b0, 32'h0);
    vecs[12] = mk(1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h100,       1'b0, 32'h0);
    vecs[13] = mk(1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h104,       1'b1, 32'h100);
    vecs[14] = mk(1'b1, 1'b1, 32'h40,        1'b1, 1'b1, 32'h108,       1'b1, 32'h104);
    vecs[15] = mk(1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h40,        1'b0, 32'h0);
    vecs[16] = mk(1'b1, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b1, 32'h44,        1'b1, 32'h40);
    vecs[17] = mk(1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    vecs[18] = mk(1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0,         1'b1, 32'hFFFF_FFFC);
    vecs[19] = mk(1'b1, 1'b1, 32'h200,       1'b1, 1'b1, 32'h4,         1'b1, 32'h0);
    vecs[20] = mk(1'b0, 1'b1, 32'h300,       1'b1, 1'b1, 32'h200,       1'b0, 32'h0);
    vecs[21] = mk(1'b1, 1'b1, 32'h500,       1'b1, 1'b1, 32'h200,       1'b0, 32'h0);
    vecs[22] = mk(1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h500,       1'b0, 32'h0);
    vecs[23] = mk(1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h504,       1'b1, 32'h500);

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) apply_row(vecs[i], i);

    // ---------------- random run against the queue model ----------------
    m_run = 1'b0; m_pend = 1'b0; m_disc = 1'b0; m_fpc = RESET_PC; m_held = RESET_PC;
    for (int cyc = 0; cyc < 900; cyc++) begin
      do_rst = (cyc == 0) || ($urandom_range(0, 149) == 0);
      if (do_rst) begin
        reset_n = 1'b0;
        redirect_valid = 1'b0;
        #1;
        check_reset_outputs($sformatf("rnd%0d async reset", cyc));
        m_run = 1'b0; m_pend = 1'b0; m_disc = 1'b0; m_fpc = RESET_PC; m_held = RESET_PC;
        exp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        ibus_ready = 1'b0; out_ready = 1'b0;
        m_iv = 1'b0; m_addr = m_fpc; m_tgt = '0;
      end else begin
        ibus_ready     = ($urandom_range(0, 3) != 0);
        out_ready      = ($urandom_range(0, 3) != 0);
        redirect_valid = ($urandom_range(0, 9) == 0);
        redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                     : 32'($urandom_range(0, 1023));
        ibus_rdata     = mem_word(ibus_address);
        m_tgt  = {redirect_pc[31:2], 2'b00};
        m_iv   = m_run && (m_pend || exp_q.size() < DEPTH);
        m_addr = m_pend ? m_held : m_fpc;
        check($sformatf("rnd%0d ibus_valid", cyc), {31'b0, ibus_valid}, {31'b0, m_iv});
        if (m_iv) check($sformatf("rnd%0d ibus_address", cyc), ibus_address, m_addr);
        check($sformatf("rnd%0d out_valid", cyc), {31'b0, out_valid}, {31'b0, exp_q.size() != 0});
        if (exp_q.size() != 0) begin
          check($sformatf("rnd%0d out_pc", cyc), out_pc, exp_q[0]);
          check($sformatf("rnd%0d out_instr", cyc), out_instr, mem_word(exp_q[0]));
        end else begin
          check($sformatf("rnd%0d out_pc idle", cyc), out_pc, 32'd0);
          check($sformatf("rnd%0d out_instr idle", cyc), out_instr, NOP);
        end
      end

      // model advance for this clock edge
      m_acc = m_iv && ibus_ready;
      if ((exp_q.size() != 0) && out_ready) void'(exp_q.pop_front());
      if (redirect_valid) begin
        exp_q.delete();
        m_fpc  = m_tgt;
        m_disc = m_iv && !ibus_ready;
      end else begin
        if (m_acc && !m_disc) begin
          exp_q.push_back(m_addr);
          m_fpc = m_addr + 32'd4;
        end
        if (m_acc) m_disc = 1'b0;
      end
      m_held = m_addr;
      m_pend = m_iv && !ibus_ready;
      m_run  = 1'b1;
      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
